// File: rtl/qpu_itcm_loader_pkg.sv
// qpu_itcm_loader_pkg
//   Shared configuration for the QPU ITCM loader: ITCM ICB widths, the
//   word-count width of a load request, the loader FSM state encoding and
//   a small address-alignment helper.
package qpu_itcm_loader_pkg;

  localparam int QPU_ITCM_ADDR_WIDTH = 16;
  localparam int QPU_ITCM_DATA_WIDTH = 64;
  localparam int QPU_ITCM_WMSK_WIDTH = 8;
  localparam int QPU_LOADER_LENW     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FILL  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

  // True when the low address bits place the access on an 8-byte ITCM word.
  function automatic logic is_aligned8(input logic [2:0] addr_lsb);
    return (addr_lsb == 3'b000);
  endfunction

endpackage

// File: rtl/qpu_loader_pack.sv
// qpu_loader_pack
//   Packs a stream of 32-bit instruction words into 64-bit ITCM words.
//   The first word of a pair lands in data[31:0] (mask 8'h0F), the second in
//   data[63:32] (mask |= 8'hF0). A word flagged as last closes the pair early,
//   leaving the upper half zero and masked off.
// Ports
//   clk, rst       clock, async active-high reset
//   clear          synchronous flush at the start of a new load
//   in_valid/in_ready/in_data/in_last   32-bit word input
//   in_complete    the word accepted this cycle completes an output word
//   out_valid/out_ready/out_data/out_mask   64-bit packed output
module qpu_loader_pack
  import qpu_itcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_complete,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_mask
);

  logic        half_r;
  logic        full_r;
  logic [63:0] data_r;
  logic [7:0]  mask_r;
  logic        in_fire_s;
  logic        out_fire_s;

  // Input is accepted only while no packed word waits for the consumer, so
  // in_fire_s and out_fire_s can never be active together.
  assign in_ready    = !full_r;
  assign in_fire_s   = in_valid && !full_r;
  assign in_complete = in_fire_s && (half_r || in_last);
  assign out_fire_s  = full_r && out_ready;
  assign out_valid   = full_r;
  assign out_data    = data_r;
  assign out_mask    = mask_r;

  // Pair state, data and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_r <= 1'b0;
      full_r <= 1'b0;
      data_r <= 64'h0;
      mask_r <= 8'h00;
    end else if (clear) begin
      half_r <= 1'b0;
      full_r <= 1'b0;
      data_r <= 64'h0;
      mask_r <= 8'h00;
    end else if (in_fire_s) begin
      if (!half_r) begin
        // Even word: the upper half is zeroed so a lone last word is clean.
        data_r <= {32'h0, in_data};
        mask_r <= 8'h0F;
        half_r <= !in_last;
        full_r <= in_last;
      end else begin
        data_r[63:32] <= in_data;
        mask_r        <= mask_r | 8'hF0;
        half_r        <= 1'b0;
        full_r        <= 1'b1;
      end
    end else if (out_fire_s) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/qpu_itcm_loader.sv
// qpu_itcm_loader
//   Write-side ICB initiator for the QPU instruction TCM. Takes 32-bit
//   instruction words from the host/debug path, packs them into 64-bit ITCM
//   words and issues ICB write commands, holding the IFU while busy.
// Ports
//   clk, rst                      clock, async active-high reset
//   load_start/base_addr/len      load request (ignored while busy)
//   host_i_valid/ready/data       32-bit instruction word stream
//   load_busy, load_done, load_err, ifu_hold   status
//   icb_cmd_*                     ICB write command channel
//   icb_rsp_valid/ready/err       ICB response channel (always accepted)
module qpu_itcm_loader
  import qpu_itcm_loader_pkg::*;
#(
  parameter int AW     = QPU_ITCM_ADDR_WIDTH,
  parameter int DW     = QPU_ITCM_DATA_WIDTH,
  parameter int MW     = QPU_ITCM_WMSK_WIDTH,
  parameter int LENW   = QPU_LOADER_LENW,
  parameter int MAXOUT = 2
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic [AW-1:0]   load_base_addr,
  input  logic [LENW-1:0] load_len,
  input  logic            host_i_valid,
  output logic            host_i_ready,
  input  logic [31:0]     host_i_data,
  output logic            load_busy,
  output logic            load_done,
  output logic            load_err,
  output logic            ifu_hold,
  output logic            icb_cmd_valid,
  input  logic            icb_cmd_ready,
  output logic [AW-1:0]   icb_cmd_addr,
  output logic            icb_cmd_read,
  output logic [DW-1:0]   icb_cmd_wdata,
  output logic [MW-1:0]   icb_cmd_wmask,
  input  logic            icb_rsp_valid,
  output logic            icb_rsp_ready,
  input  logic            icb_rsp_err
);

  localparam logic [1:0] MAXOUT_C = 2'(MAXOUT);

  loader_state_e   state_r;
  loader_state_e   state_next_s;
  logic [AW-1:0]   addr_r;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] count_r;
  logic [LENW-1:0] count_inc_s;
  logic [1:0]      outstanding_r;
  logic            load_busy_r;
  logic            load_done_r;
  logic            load_err_r;
  logic            done_next_s;
  logic            start_accept_s;
  logic            host_fire_s;
  logic            last_word_s;
  logic            cmd_fire_s;
  logic            rsp_take_s;
  logic            pack_in_ready_s;
  logic            pack_complete_s;
  logic            pack_out_valid_s;
  logic [63:0]     pack_data_s;
  logic [7:0]      pack_mask_s;

  assign start_accept_s = load_start && (state_r == ST_IDLE);
  assign host_i_ready   = (state_r == ST_FILL) && pack_in_ready_s;
  assign host_fire_s    = host_i_valid && host_i_ready;
  assign count_inc_s    = count_r + {{(LENW-1){1'b0}}, 1'b1};
  assign last_word_s    = (count_inc_s == len_r);

  // Command valid is decoded from registers only, so addr/data/mask (also
  // registers) cannot move between the valid rise and the handshake.
  assign icb_cmd_valid  = (state_r == ST_ISSUE) && pack_out_valid_s &&
                          (outstanding_r < MAXOUT_C);
  assign cmd_fire_s     = icb_cmd_valid && icb_cmd_ready;
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign rsp_take_s     = icb_rsp_valid && (outstanding_r != 2'd0);

  assign icb_cmd_addr   = addr_r;
  assign icb_cmd_read   = 1'b0;
  assign icb_cmd_wdata  = pack_data_s;
  assign icb_cmd_wmask  = pack_mask_s;
  assign icb_rsp_ready  = 1'b1;
  assign load_busy      = load_busy_r;
  assign ifu_hold       = load_busy_r;
  assign load_done      = load_done_r;
  assign load_err       = load_err_r;

  qpu_loader_pack u_pack (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_accept_s),
    .in_valid    (host_i_valid && (state_r == ST_FILL)),
    .in_ready    (pack_in_ready_s),
    .in_data     (host_i_data),
    .in_last     (last_word_s),
    .in_complete (pack_complete_s),
    .out_valid   (pack_out_valid_s),
    .out_ready   (cmd_fire_s),
    .out_data    (pack_data_s),
    .out_mask    (pack_mask_s)
  );

  // Next-state decode and completion pulse request.
  always_comb begin
    state_next_s = state_r;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) state_next_s = ST_CHECK;
        else            state_next_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (!is_aligned8(addr_r[2:0])) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else if (len_r == {LENW{1'b0}}) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_FILL: begin
        if (pack_complete_s) state_next_s = ST_ISSUE;
        else                 state_next_s = ST_FILL;
      end
      ST_ISSUE: begin
        if (cmd_fire_s) begin
          if (count_r == len_r) state_next_s = ST_DRAIN;
          else                  state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == 2'd0) begin
          state_next_s = ST_DONE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      load_busy_r <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      load_busy_r <= (state_next_s != ST_IDLE);
      load_done_r <= done_next_s;
    end
  end

  // Address and word-count bookkeeping; the address wraps modulo 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= {AW{1'b0}};
      len_r   <= {LENW{1'b0}};
      count_r <= {LENW{1'b0}};
    end else if (start_accept_s) begin
      addr_r  <= load_base_addr;
      len_r   <= load_len;
      count_r <= {LENW{1'b0}};
    end else begin
      if (cmd_fire_s) addr_r <= addr_r + {{(AW-4){1'b0}}, 4'd8};
      else            addr_r <= addr_r;
      if (host_fire_s) count_r <= count_inc_s;
      else             count_r <= count_r;
    end
  end

  // Outstanding-command counter; a same-cycle issue and response cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= 2'd0;
    end else begin
      case ({cmd_fire_s, rsp_take_s})
        2'b10:   outstanding_r <= outstanding_r + 2'd1;
        2'b01:   outstanding_r <= outstanding_r - 2'd1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Sticky error: cleared by an accepted start, set by a misaligned base or
  // an error response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_r <= 1'b0;
    end else if (start_accept_s) begin
      load_err_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && !is_aligned8(addr_r[2:0])) begin
      load_err_r <= 1'b1;
    end else if (rsp_take_s && icb_rsp_err) begin
      load_err_r <= 1'b1;
    end else begin
      load_err_r <= load_err_r;
    end
  end

endmodule

// File: tb/tb_qpu_itcm_loader.sv
// Self-checking bench for qpu_itcm_loader: a table of directed loads plus
// hand-written sequences for misaligned timing, outstanding limit, command
// stall stability, ignored start while busy and reset during issue.
module tb_qpu_itcm_loader;

  localparam int MAXOUT = 2;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [15:0] load_base_addr;
  logic [15:0] load_len;
  logic        host_i_valid;
  logic        host_i_ready;
  logic [31:0] host_i_data;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        ifu_hold;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [15:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;

  qpu_itcm_loader #(.MAXOUT(MAXOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_start     (load_start),
    .load_base_addr (load_base_addr),
    .load_len       (load_len),
    .host_i_valid   (host_i_valid),
    .host_i_ready   (host_i_ready),
    .host_i_data    (host_i_data),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .ifu_hold       (ifu_hold),
    .icb_cmd_valid  (icb_cmd_valid),
    .icb_cmd_ready  (icb_cmd_ready),
    .icb_cmd_addr   (icb_cmd_addr),
    .icb_cmd_read   (icb_cmd_read),
    .icb_cmd_wdata  (icb_cmd_wdata),
    .icb_cmd_wmask  (icb_cmd_wmask),
    .icb_rsp_valid  (icb_rsp_valid),
    .icb_rsp_ready  (icb_rsp_ready),
    .icb_rsp_err    (icb_rsp_err)
  );

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [31:0] w0;
    logic        err_rsp;
    logic        exp_err;
    int          exp_ncmd;
    logic [15:0] a_first;
    logic [63:0] d_first;
    logic [7:0]  m_first;
    logic [15:0] a_last;
    logic [63:0] d_last;
    logic [7:0]  m_last;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // main-owned controls
  int          feed_gen = 0;
  int          feed_len = 0;
  logic [31:0] feed_w0 = 32'h0;
  int          rsp_delay = 1;
  int          rsp_allow = 1 << 30;
  int          err_target = -1;

  // monitor/responder-owned observations
  int          cyc = 0;
  int          rsp_sent = 0;
  int          due_q[$];
  logic [15:0] cmd_addr_q[$];
  logic [63:0] cmd_data_q[$];
  logic [7:0]  cmd_mask_q[$];
  int          done_cnt = 0;
  int          cmdv_cnt = 0;
  int          both_cnt = 0;
  int          guard_viol = 0;
  int          stab_viol = 0;
  int          mdl_out = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Host word feeder: presents feed_w0+idx, advancing when accepted.
  initial begin
    int idx;
    int my_gen;
    idx = 0;
    my_gen = 0;
    host_i_valid = 1'b0;
    host_i_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (my_gen != feed_gen) begin
        my_gen = feed_gen;
        idx = 0;
      end
      if (idx < feed_len) begin
        host_i_valid = 1'b1;
        host_i_data  = feed_w0 + 32'(idx);
      end else begin
        host_i_valid = 1'b0;
        host_i_data  = 32'h0;
      end
      #1;
      if (!rst && host_i_valid && host_i_ready) idx++;
    end
  end

  // ICB responder and command monitor with an outstanding-count model.
  initial begin
    logic        stall_act;
    logic [15:0] s_addr;
    logic [63:0] s_data;
    logic [7:0]  s_mask;
    logic        hs;
    stall_act = 1'b0;
    s_addr = 16'h0;
    s_data = 64'h0;
    s_mask = 8'h0;
    icb_rsp_valid = 1'b0;
    icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        due_q.delete();
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc && rsp_sent < rsp_allow) begin
        icb_rsp_valid = 1'b1;
        icb_rsp_err   = (rsp_sent == err_target);
        void'(due_q.pop_front());
        rsp_sent++;
      end else begin
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
      end
      #1;
      if (rst) begin
        mdl_out = 0;
        stall_act = 1'b0;
      end else begin
        if (icb_cmd_valid) begin
          cmdv_cnt++;
          if (mdl_out >= MAXOUT) guard_viol++;
        end
        if (icb_cmd_valid && !icb_cmd_ready) begin
          if (stall_act && (icb_cmd_addr != s_addr || icb_cmd_wdata != s_data ||
                            icb_cmd_wmask != s_mask)) stab_viol++;
          stall_act = 1'b1;
          s_addr = icb_cmd_addr;
          s_data = icb_cmd_wdata;
          s_mask = icb_cmd_wmask;
        end else begin
          stall_act = 1'b0;
        end
        hs = icb_cmd_valid && icb_cmd_ready;
        if (hs) begin
          cmd_addr_q.push_back(icb_cmd_addr);
          cmd_data_q.push_back(icb_cmd_wdata);
          cmd_mask_q.push_back(icb_cmd_wmask);
          due_q.push_back(cyc + rsp_delay);
          mdl_out++;
        end
        if (hs && icb_rsp_valid) both_cnt++;
        if (icb_rsp_valid && mdl_out > 0) mdl_out--;
        if (load_done) done_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_load(input logic [15:0] base, input logic [15:0] len,
                            input logic [31:0] w0);
    @(negedge clk);
    feed_w0 = w0;
    feed_len = int'(len);
    feed_gen++;
    load_base_addr = base;
    load_len = len;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cmdv(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (icb_cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int   q0;
    int   d0;
    int   c0;
    int   n;
    logic ok;
    q0 = cmd_addr_q.size();
    d0 = done_cnt;
    c0 = cmdv_cnt;
    if (v.err_rsp) err_target = rsp_sent;
    else           err_target = -1;
    start_load(v.base, v.len, v.w0);
    wait_done(d0, 300, ok);
    chk({tag, "_done_timeout"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    err_target = -1;
    n = cmd_addr_q.size() - q0;
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_err"}, 64'(load_err), 64'(v.exp_err));
    chk({tag, "_ncmd"}, 64'(n), 64'(v.exp_ncmd));
    chk({tag, "_busy_idle"}, {62'd0, load_busy, ifu_hold}, 64'd0);
    if (v.exp_ncmd == 0) begin
      chk({tag, "_cmdv_cycles"}, 64'(cmdv_cnt - c0), 64'd0);
    end else if (n == v.exp_ncmd) begin
      chk({tag, "_addr_first"}, 64'(cmd_addr_q[q0]), 64'(v.a_first));
      chk({tag, "_data_first"}, cmd_data_q[q0], v.d_first);
      chk({tag, "_mask_first"}, 64'(cmd_mask_q[q0]), 64'(v.m_first));
      chk({tag, "_addr_last"}, 64'(cmd_addr_q[q0+n-1]), 64'(v.a_last));
      chk({tag, "_data_last"}, cmd_data_q[q0+n-1], v.d_last);
      chk({tag, "_mask_last"}, 64'(cmd_mask_q[q0+n-1]), 64'(v.m_last));
    end
  endtask

  vec_t vecs[7];

  initial begin
    int   q0;
    int   d0;
    int   h0;
    int   b0;
    int   s0;
    logic ok;
    vec_t rv;

    vecs[0] = '{16'h0100, 16'd4, 32'hA0, 1'b0, 1'b0, 2,
                16'h0100, 64'h000000A1_000000A0, 8'hFF,
                16'h0108, 64'h000000A3_000000A2, 8'hFF};
    vecs[1] = '{16'h0200, 16'd3, 32'hB0, 1'b0, 1'b0, 2,
                16'h0200, 64'h000000B1_000000B0, 8'hFF,
                16'h0208, 64'h00000000_000000B2, 8'h0F};
    vecs[2] = '{16'h0104, 16'd4, 32'hA0, 1'b0, 1'b1, 0,
                16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0};
    vecs[3] = '{16'hFFF8, 16'd4, 32'hC0, 1'b0, 1'b0, 2,
                16'hFFF8, 64'h000000C1_000000C0, 8'hFF,
                16'h0000, 64'h000000C3_000000C2, 8'hFF};
    vecs[4] = '{16'h0300, 16'd1, 32'hD0, 1'b0, 1'b0, 1,
                16'h0300, 64'h00000000_000000D0, 8'h0F,
                16'h0300, 64'h00000000_000000D0, 8'h0F};
    vecs[5] = '{16'h0400, 16'd0, 32'h0, 1'b0, 1'b0, 0,
                16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0};
    vecs[6] = '{16'h0700, 16'd2, 32'h11, 1'b1, 1'b1, 1,
                16'h0700, 64'h00000012_00000011, 8'hFF,
                16'h0700, 64'h00000012_00000011, 8'hFF};

    rst = 1'b1;
    load_start = 1'b0;
    load_base_addr = 16'h0;
    load_len = 16'h0;
    icb_cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rsp_ready", 64'(icb_rsp_ready), 64'd1);
    chk("rst_cmd_valid", 64'(icb_cmd_valid), 64'd0);
    chk("rst_busy_hold", {62'd0, load_busy, ifu_hold}, 64'd0);
    chk("rst_done_err", {62'd0, load_done, load_err}, 64'd0);
    chk("rst_host_ready", 64'(host_i_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Misaligned base: done pulse exactly 2 cycles after start.
    @(negedge clk);
    feed_len = 0;
    feed_gen++;
    load_base_addr = 16'h010C;
    load_len = 16'd2;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #2;
    chk("mis_c1_busy", 64'(load_busy), 64'd1);
    chk("mis_c1_done", 64'(load_done), 64'd0);
    @(negedge clk);
    #2;
    chk("mis_c2_done_err", {62'd0, load_done, load_err}, 64'd3);
    chk("mis_c2_busy", 64'(load_busy), 64'd0);
    @(negedge clk);
    #2;
    chk("mis_c3_done_err", {62'd0, load_done, load_err}, 64'd1);

    // Outstanding limit with responses withheld, plus a start while busy.
    rsp_delay = 3;
    rsp_allow = rsp_sent;
    q0 = cmd_addr_q.size();
    d0 = done_cnt;
    b0 = both_cnt;
    h0 = guard_viol;
    start_load(16'h0600, 16'd8, 32'hF0);
    repeat (4) @(negedge clk);
    load_base_addr = 16'h0800;
    load_len = 16'd2;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("hold_handshakes", 64'(cmd_addr_q.size() - q0), 64'd2);
    chk("hold_cmd_valid", 64'(icb_cmd_valid), 64'd0);
    chk("hold_busy", 64'(load_busy), 64'd1);
    rsp_allow = 1 << 30;
    wait_done(d0, 300, ok);
    chk("hold_done_timeout", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    chk("hold_ncmd", 64'(cmd_addr_q.size() - q0), 64'd4);
    chk("hold_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("hold_guard_viol", 64'(guard_viol - h0), 64'd0);
    chk("hold_same_cycle_seen", 64'(both_cnt > b0), 64'd1);
    chk("hold_err", 64'(load_err), 64'd0);
    if (cmd_addr_q.size() - q0 == 4) begin
      chk("busy_start_addr3", 64'(cmd_addr_q[q0+2]), 64'h0610);
      chk("busy_start_addr4", 64'(cmd_addr_q[q0+3]), 64'h0618);
      chk("busy_start_data4", cmd_data_q[q0+3], 64'h000000F7_000000F6);
    end
    rsp_delay = 1;

    // Command stalled by cmd_ready=0: addr/data/mask must hold.
    s0 = stab_viol;
    q0 = cmd_addr_q.size();
    d0 = done_cnt;
    icb_cmd_ready = 1'b0;
    start_load(16'h0500, 16'd2, 32'hE0);
    wait_cmdv(40, ok);
    chk("stall_valid_timeout", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    icb_cmd_ready = 1'b1;
    wait_done(d0, 300, ok);
    chk("stall_done_timeout", 64'(ok), 64'd1);
    chk("stall_stability", 64'(stab_viol - s0), 64'd0);
    chk("stall_ncmd", 64'(cmd_addr_q.size() - q0), 64'd1);
    if (cmd_addr_q.size() - q0 == 1) begin
      chk("stall_addr", 64'(cmd_addr_q[q0]), 64'h0500);
      chk("stall_data", cmd_data_q[q0], 64'h000000E1_000000E0);
    end

    // Reset asserted while a command is pending.
    icb_cmd_ready = 1'b0;
    start_load(16'h0900, 16'd4, 32'h20);
    wait_cmdv(40, ok);
    chk("rstmid_valid_timeout", 64'(ok), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_cmd_valid", 64'(icb_cmd_valid), 64'd0);
    chk("rstmid_busy_hold", {62'd0, load_busy, ifu_hold}, 64'd0);
    chk("rstmid_addr", 64'(icb_cmd_addr), 64'd0);
    chk("rstmid_wdata", icb_cmd_wdata, 64'd0);
    chk("rstmid_wmask_read", {55'd0, icb_cmd_read, icb_cmd_wmask}, 64'd0);
    chk("rstmid_rsp_ready", 64'(icb_rsp_ready), 64'd1);
    chk("rstmid_misc", {61'd0, load_done, load_err, host_i_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    icb_cmd_ready = 1'b1;
    rv = '{16'h0A00, 16'd2, 32'h30, 1'b0, 1'b0, 1,
           16'h0A00, 64'h00000031_00000030, 8'hFF,
           16'h0A00, 64'h00000031_00000030, 8'hFF};
    do_vec(rv, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
